// File: rtl/la_wb_counter_arbiter.sv
// la_wb_counter_arbiter: user-project counter with fixed-priority updates
// (LA load > Wishbone COUNT write > increment) and a stall/drop Wishbone slave.
module la_wb_counter_arbiter #(
   parameter int          WIDTH     = 32,
   parameter int          IO_BITS   = 16,
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
   parameter int          STALL_MAX = 255
) (
   input  logic               wb_clk_i,
   input  logic               resetb,
   input  logic               wbs_cyc_i,
   input  logic               wbs_stb_i,
   input  logic               wbs_we_i,
   input  logic [3:0]         wbs_sel_i,
   input  logic [31:0]        wbs_adr_i,
   input  logic [31:0]        wbs_dat_i,
   output logic               wbs_ack_o,
   output logic [31:0]        wbs_dat_o,
   input  logic [WIDTH-1:0]   la_data_in,
   input  logic [WIDTH-1:0]   la_oenb,
   input  logic               la_step,
   output logic [WIDTH-1:0]   count,
   output logic [IO_BITS-1:0] io_out,
   output logic [IO_BITS-1:0] io_oeb
);
   localparam int SW = (STALL_MAX < 1) ? 1 : $clog2(STALL_MAX + 1);

   typedef enum logic [1:0] {IDLE, WB_WAIT, WB_ACK} state_t;

   state_t           r_state, w_state_nxt;
   logic [SW-1:0]    r_stall, w_stall_nxt;
   logic [31:0]      r_rdata, w_rdata_nxt;
   logic [WIDTH-1:0] r_count, w_count_nxt;
   logic             r_run, r_step_mode, r_oe_en, r_wr_dropped, r_wrapped, r_step_d;
   logic             w_req, w_hit, w_is_count, w_is_ctrl, w_la_idle;
   logic             w_wr_acc, w_ctrl_wr, w_drop, w_rose, w_inc, w_wrap;
   logic [31:0]      w_ctrl, w_count32, w_merged;

   assign w_req      = wbs_cyc_i & wbs_stb_i;
   assign w_hit      = wbs_adr_i[31:3] == BASE_ADDR[31:3];
   assign w_is_count = wbs_adr_i[2:0] == 3'd0;
   assign w_is_ctrl  = wbs_adr_i[2:0] == 3'd4;
   assign w_la_idle  = &la_oenb;
   assign w_ctrl     = {22'd0, r_wrapped, r_wr_dropped, 5'd0, r_oe_en, r_step_mode, r_run};
   assign w_count32  = 32'(r_count);
   assign w_rose     = la_step & ~r_step_d;
   assign w_inc      = r_run & (~r_step_mode | w_rose);
   assign w_wrap     = w_la_idle & ~w_wr_acc & w_inc & (&r_count);

   for (genvar b = 0; b < 4; b++) begin : g_lane
      assign w_merged[8*b +: 8] = wbs_sel_i[b] ? wbs_dat_i[8*b +: 8] : w_count32[8*b +: 8];
   end

   always_comb begin
      w_state_nxt = r_state;
      w_stall_nxt = r_stall;
      w_rdata_nxt = r_rdata;
      w_wr_acc    = 1'b0;
      w_ctrl_wr   = 1'b0;
      w_drop      = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_req && w_hit) begin
               w_state_nxt = WB_ACK;
               w_rdata_nxt = 32'd0;
               if (!wbs_we_i)
                  w_rdata_nxt = w_is_count ? w_count32 : w_is_ctrl ? w_ctrl : 32'd0;
               else if (w_is_ctrl)
                  w_ctrl_wr = 1'b1;
               else if (w_is_count && w_la_idle)
                  w_wr_acc = 1'b1;
               else if (w_is_count) begin
                  w_state_nxt = WB_WAIT;
                  w_stall_nxt = '0;
               end
            end
         end
         WB_WAIT: begin
            if (!w_req)
               w_state_nxt = IDLE;
            else if (w_la_idle) begin
               w_wr_acc    = 1'b1;
               w_state_nxt = WB_ACK;
            end else if (r_stall == SW'(STALL_MAX)) begin
               w_drop      = 1'b1;
               w_state_nxt = WB_ACK;
            end else
               w_stall_nxt = r_stall + 1'b1;
         end
         WB_ACK:  w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      w_count_nxt = r_count;
      if (!w_la_idle)
         w_count_nxt = (r_count & la_oenb) | (la_data_in & ~la_oenb);
      else if (w_wr_acc)
         w_count_nxt = w_merged[WIDTH-1:0];
      else if (w_inc)
         w_count_nxt = r_count + 1'b1;
   end

   always_ff @(posedge wb_clk_i) begin
      if (!resetb) begin
         r_state      <= IDLE;
         r_stall      <= '0;
         r_rdata      <= 32'd0;
         r_count      <= '0;
         r_run        <= 1'b1;
         r_step_mode  <= 1'b0;
         r_oe_en      <= 1'b0;
         r_wr_dropped <= 1'b0;
         r_wrapped    <= 1'b0;
         r_step_d     <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_stall      <= w_stall_nxt;
         r_rdata      <= w_rdata_nxt;
         r_count      <= w_count_nxt;
         r_step_d     <= la_step;
         if (w_ctrl_wr && wbs_sel_i[0])
            {r_oe_en, r_step_mode, r_run} <= wbs_dat_i[2:0];
         // a new event in the same cycle as a clear keeps the sticky bit set
         r_wr_dropped <= w_drop | (r_wr_dropped & ~(w_ctrl_wr & wbs_sel_i[1] & wbs_dat_i[8]));
         r_wrapped    <= w_wrap | (r_wrapped & ~(w_ctrl_wr & wbs_sel_i[1] & wbs_dat_i[9]));
      end
   end

   assign wbs_ack_o = r_state == WB_ACK;
   assign wbs_dat_o = wbs_ack_o ? r_rdata : 32'd0;
   assign count     = r_count;
   assign io_out    = r_count[IO_BITS-1:0];
   assign io_oeb    = {IO_BITS{~r_oe_en}};
endmodule

// File: tb/tb_la_wb_counter_arbiter.sv
// tb_la_wb_counter_arbiter: directed checks of counter priority, Wishbone stall/drop and CTRL.
module tb_la_wb_counter_arbiter;
   localparam logic [31:0] BASE = 32'h3000_0000;
   localparam logic [31:0] CTRL = 32'h3000_0004;

   logic        clk = 1'b0;
   logic        resetb;
   logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_adr_i, wbs_dat_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;
   logic [31:0] la_data_in, la_oenb;
   logic        la_step;
   logic [31:0] count;
   logic [15:0] io_out, io_oeb;

   int          total = 0;
   int          bad = 0;
   int          lat, acks, at;
   logic [31:0] rd, ca;

   la_wb_counter_arbiter dut (
      .wb_clk_i(clk), .resetb(resetb),
      .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
      .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
      .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
      .la_data_in(la_data_in), .la_oenb(la_oenb), .la_step(la_step),
      .count(count), .io_out(io_out), .io_oeb(io_oeb)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drive(input logic we, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
      wbs_adr_i = adr;  wbs_dat_i = dat;  wbs_sel_i = sel;
   endtask

   task automatic release_bus();
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
   endtask

   // drives at a negedge, returns one negedge after the ack with the bus idle
   task automatic wb(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                     input logic [3:0] sel, output int l, output logic [31:0] r, output logic [31:0] c);
      drive(we, adr, dat, sel);
      l = 0;
      while (l < 400) begin
         @(negedge clk);
         l++;
         if (wbs_ack_o) break;
      end
      r = wbs_dat_o;
      c = count;
      chk("wb_ack_seen", 32'(wbs_ack_o), 32'd1);
      release_bus();
      @(negedge clk);
   endtask

   initial begin
      resetb = 1'b0; la_step = 1'b0; la_data_in = 32'd0; la_oenb = '1;
      wbs_sel_i = 4'h0; wbs_adr_i = 32'd0; wbs_dat_i = 32'd0;
      release_bus();
      tick(3);
      chk("rst_count", count, 32'd0);
      chk("rst_ack", 32'(wbs_ack_o), 32'd0);
      chk("rst_dat", wbs_dat_o, 32'd0);
      chk("rst_oeb", 32'(io_oeb), 32'h0000_FFFF);

      resetb = 1'b1;
      acks = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (wbs_ack_o) acks++;
      end
      chk("run_10_count", count, 32'd10);
      chk("run_10_noack", 32'(acks), 32'd0);

      wb(1'b0, CTRL, 32'd0, 4'hF, lat, rd, ca);
      chk("rd_ctrl_lat", 32'(lat), 32'd1);
      chk("rd_ctrl_rst", rd, 32'h1);
      chk("ack_one_cycle", 32'(wbs_ack_o), 32'd0);
      chk("dat_idle_zero", wbs_dat_o, 32'd0);
      chk("count_after_rd", count, 32'd12);

      wb(1'b1, CTRL, 32'h5, 4'hF, lat, rd, ca);
      chk("wr_ctrl_lat", 32'(lat), 32'd1);
      chk("oe_enabled", 32'(io_oeb), 32'd0);

      wb(1'b1, BASE, 32'h0000_AB60, 4'hF, lat, rd, ca);
      chk("wr_count_lat", 32'(lat), 32'd1);
      chk("wr_count_at_ack", ca, 32'h0000_AB60);
      chk("io_out_next", 32'(io_out), 32'h0000_AB61);

      la_oenb = '0; la_data_in = 32'h1234;
      drive(1'b1, BASE, 32'h55, 4'hF);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_noack", 32'(wbs_ack_o), 32'd0);
         chk("stall_la_count", count, 32'h1234);
      end
      la_oenb = '1;
      @(negedge clk);
      chk("stall_release_ack", 32'(wbs_ack_o), 32'd1);
      chk("stall_write_lands", count, 32'h55);
      chk("stall_write_dat", wbs_dat_o, 32'd0);
      release_bus();
      @(negedge clk);
      chk("stall_after_inc", count, 32'h56);

      la_oenb = '0; la_data_in = 32'hCAFE_0000;
      drive(1'b1, BASE, 32'h99, 4'hF);
      acks = 0; at = 0;
      for (int i = 1; i <= 300; i++) begin
         @(negedge clk);
         if (wbs_ack_o) begin
            acks++;
            at = i;
            release_bus();
         end
      end
      chk("drop_one_ack", 32'(acks), 32'd1);
      chk("drop_ack_window", 32'(at >= 250 && at <= 260), 32'd1);
      chk("drop_la_wins", count, 32'hCAFE_0000);
      la_oenb = '1; la_data_in = 32'd0;
      wb(1'b0, CTRL, 32'd0, 4'hF, lat, rd, ca);
      chk("ctrl_dropped_set", rd, 32'h105);
      wb(1'b1, CTRL, 32'h105, 4'hF, lat, rd, ca);
      wb(1'b0, CTRL, 32'd0, 4'hF, lat, rd, ca);
      chk("ctrl_dropped_clr", rd, 32'h005);

      wb(1'b1, CTRL, 32'h3, 4'hF, lat, rd, ca);
      chk("oe_disabled", 32'(io_oeb), 32'h0000_FFFF);
      wb(1'b1, BASE, 32'h100, 4'hF, lat, rd, ca);
      chk("step_load", count, 32'h100);
      tick(3);
      chk("step_hold", count, 32'h100);
      for (int i = 0; i < 3; i++) begin
         la_step = 1'b1; tick(1);
         la_step = 1'b0; tick(1);
      end
      chk("step_three", count, 32'h103);
      la_step = 1'b1; tick(5);
      chk("step_held_once", count, 32'h104);
      la_step = 1'b0; tick(1);

      wb(1'b1, BASE, 32'hAABB_CCDD, 4'b0101, lat, rd, ca);
      chk("sel_partial", count, 32'h00BB_01DD);
      wb(1'b0, BASE, 32'd0, 4'hF, lat, rd, ca);
      chk("rd_count", rd, 32'h00BB_01DD);
      wb(1'b0, BASE + 32'd2, 32'd0, 4'hF, lat, rd, ca);
      chk("miss_lat", 32'(lat), 32'd1);
      chk("miss_dat", rd, 32'd0);
      drive(1'b0, BASE + 32'd8, 32'd0, 4'hF);
      acks = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (wbs_ack_o) acks++;
      end
      release_bus();
      tick(1);
      chk("outside_noack", 32'(acks), 32'd0);

      wb(1'b1, CTRL, 32'h1, 4'hF, lat, rd, ca);
      wb(1'b1, BASE, 32'hFFFF_FFFF, 4'hF, lat, rd, ca);
      chk("wrap_loaded", ca, 32'hFFFF_FFFF);
      chk("wrap_zero", count, 32'd0);
      wb(1'b0, CTRL, 32'd0, 4'hF, lat, rd, ca);
      chk("wrap_flag", rd, 32'h201);

      la_oenb = '0; la_data_in = 32'h77;
      drive(1'b1, BASE, 32'h42, 4'hF);
      tick(3);
      chk("rstwait_noack", 32'(wbs_ack_o), 32'd0);
      resetb = 1'b0;
      tick(1);
      chk("rstwait_count", count, 32'd0);
      chk("rstwait_ack", 32'(wbs_ack_o), 32'd0);
      resetb = 1'b1; la_oenb = '1;
      release_bus();
      acks = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (wbs_ack_o) acks++;
      end
      chk("rstwait_no_late_ack", 32'(acks), 32'd0);
      chk("rstwait_runs", count, 32'd3);
      wb(1'b0, CTRL, 32'd0, 4'hF, lat, rd, ca);
      chk("rstwait_idle_lat", 32'(lat), 32'd1);
      chk("rstwait_ctrl", rd, 32'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
